// File: rtl/unified_memory_wait.sv
`default_nettype none
// ============================================================================
// Module   : unified_memory_wait
// Purpose  : Unified instruction/data memory with separate fetch and data
//            request ports over one shared word array, req/valid handshake,
//            configurable wait states, byte-enabled writes and flagging of
//            misaligned / out-of-range accesses.
// Option   : define UNIFIED_MEMORY_WAIT_PERF_EN to add i_count / d_count
//            completion counters.
// Revision : 1.0 - initial release
// ============================================================================
module unified_memory_wait #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    output logic                    i_valid,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_valid,
    output logic                    err,
    output logic                    busy
`ifdef UNIFIED_MEMORY_WAIT_PERF_EN
    ,
    output logic [31:0]             i_count,
    output logic [31:0]             d_count
`endif
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(BYTES);
    localparam int IDXW  = $clog2(DEPTH_WORDS);
    localparam int TOP   = OFFS + IDXW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state;
    logic [7:0]              cnt;
    logic                    sel_d;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic                    lat_we;
    logic [BYTES-1:0]        lat_be;
    logic [DATA_WIDTH-1:0]   lat_wdata;

    logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

    // Access currently being served: live inputs while idle, latched copy after
    logic                    cur_d;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic                    cur_we;
    logic [BYTES-1:0]        cur_be;
    logic [DATA_WIDTH-1:0]   cur_wdata;
    logic                    accept;
    logic                    enter_resp;
    logic                    misaligned;
    logic                    out_of_range;
    logic                    illegal;
    logic [IDXW-1:0]         idx;

    // Select between live request inputs (IDLE) and the latched request
    always_comb begin
        cur_d     = sel_d;
        cur_addr  = lat_addr;
        cur_we    = lat_we;
        cur_be    = lat_be;
        cur_wdata = lat_wdata;
        if (state == ST_IDLE) begin
            cur_d     = d_req;
            cur_addr  = d_req ? d_addr : i_addr;
            cur_we    = d_req & d_we;
            cur_be    = d_be;
            cur_wdata = d_wdata;
        end
    end

    assign accept     = (state == ST_IDLE) && (d_req || i_req);
    // The edge that moves the FSM into RESP is where the access takes effect
    assign enter_resp = !reset &&
                        ((accept && (WAIT_CYCLES == 0)) ||
                         ((state == ST_WAIT) && (cnt == 8'd0)));
    assign misaligned = (cur_addr & ADDR_WIDTH'(BYTES - 1)) != '0;
    assign idx        = cur_addr[TOP-1:OFFS];
    assign illegal    = misaligned || out_of_range;

    // Address bits above the array are only checkable if the address has any
    generate
        if (TOP < ADDR_WIDTH) begin : g_range_chk
            assign out_of_range = |cur_addr[ADDR_WIDTH-1:TOP];
        end else begin : g_range_none
            assign out_of_range = 1'b0;
        end
    endgenerate

    // Byte-lane write into the shared array; contents survive reset
    always_ff @(posedge clk) begin
        if (enter_resp && cur_we && !illegal) begin
            for (int b = 0; b < BYTES; b++) begin
                if (cur_be[b]) begin
                    mem[idx][8*b +: 8] <= cur_wdata[8*b +: 8];
                end
            end
        end
    end

    // Control FSM with registered handshake outputs and read data
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= 8'd0;
            sel_d     <= 1'b0;
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_be    <= '0;
            lat_wdata <= '0;
            i_valid   <= 1'b0;
            d_valid   <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            err     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        sel_d     <= cur_d;
                        lat_addr  <= cur_addr;
                        lat_we    <= cur_we;
                        lat_be    <= cur_be;
                        lat_wdata <= cur_wdata;
                        busy      <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= 8'(WAIT_CYCLES - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 8'd0) begin
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
            if (enter_resp) begin
                if (cur_d) d_valid <= 1'b1;
                else       i_valid <= 1'b1;
                err <= illegal;
                if (illegal) begin
                    if (cur_d) d_rdata <= '0;
                    else       i_rdata <= '0;
                end else if (!cur_we) begin
                    if (cur_d) d_rdata <= mem[idx];
                    else       i_rdata <= mem[idx];
                end
            end
        end
    end

`ifdef UNIFIED_MEMORY_WAIT_PERF_EN
    // Completion counters, bumped on the edge that raises each valid pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            i_count <= 32'd0;
            d_count <= 32'd0;
        end else if (enter_resp) begin
            if (cur_d) d_count <= d_count + 32'd1;
            else       i_count <= i_count + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire
